// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared FSM encoding and default widths for the data-memory responder.
package dm_responder_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/dm_responder_array.sv
// dm_array: single-port RAM with synchronous write and registered (read-first) read.
module dm_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);
  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: handshaked data-memory target with programmable wait states and range checking.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, err_q, rsp_err_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q, arr_rdata;
  logic                  accept;
  assign accept    = req_valid & req_ready;
  assign req_ready = state_q == ST_IDLE;
  assign rsp_valid = state_q == ST_RESP;
  assign busy      = state_q != ST_IDLE;
  assign rsp_err   = rsp_err_q;
  // Stores echo the written word; the array read port is read-first and would return stale data.
  assign rsp_rdata = (rsp_valid && !rsp_err_q) ? (we_q ? wdata_q : arr_rdata) : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        cnt_d   = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
      end
      ST_WAIT: if (cnt_q == '0) state_d = ST_ACCESS;
               else cnt_d = cnt_q - 4'd1;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= |req_addr[ADDR_W-1:DEPTH_LOG2];
        addr_q  <= req_addr[DEPTH_LOG2-1:0];
        wdata_q <= req_wdata;
      end
      if (state_q == ST_ACCESS) rsp_err_q <= err_q;
      else if (rsp_valid && rsp_ready) rsp_err_q <= 1'b0;
    end
  end
  dm_array #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_array (
    .clk     (clk),
    .en_i    (state_q == ST_ACCESS && !err_q),
    .we_i    (we_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed self-checking bench for dm_responder (WAIT_CYCLES=2 and 0 instances).
module tb_dm_responder;
  logic        clk = 1'b0;
  logic        rst_f;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
  logic [15:0] req_addr_b;
  logic [31:0] req_wdata_b, rsp_rdata_b;
  int          n_run = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  dm_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_f(rst_f), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );
  dm_responder #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_f(rst_f), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xact(input logic we, input logic [15:0] a, input logic [31:0] d, input bit ack,
                      output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    rd = rsp_rdata; er = rsp_err;
    if (ack) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        v_we [4];
    logic [31:0] v_d [4], v_exp [4];
    int          k = 0, j = 0, last = -1, cyc = 0;
    rst_f = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    rst_f = 1'b1;
    xact(1'b1, 16'h0005, 32'hDEADBEEF, 1, rd, er, lat);
    check("t1_store_rdata", rd, 32'hDEADBEEF);
    check("t1_store_err", 32'(er), 0);
    check("t1_latency", lat, 4);
    xact(1'b1, 16'h0000, 32'hCAFEF00D, 1, rd, er, lat);
    xact(1'b1, 16'h03FF, 32'h12345678, 1, rd, er, lat);
    check("last_word_store_err", 32'(er), 0);
    xact(1'b1, 16'h0010, 32'h11111111, 1, rd, er, lat);
    xact(1'b0, 16'h0005, 32'h0, 1, rd, er, lat);
    check("t2_load5", rd, 32'hDEADBEEF);
    check("t2_load_latency", lat, 4);
    xact(1'b0, 16'h03FF, 32'h0, 1, rd, er, lat);
    check("t2_load3ff", rd, 32'h12345678);
    check("t2_load3ff_err", 32'(er), 0);
    xact(1'b1, 16'h0400, 32'hFFFFFFFF, 1, rd, er, lat);
    check("t3_oor_err", 32'(er), 1);
    check("t3_oor_rdata", rd, 0);
    check("t3_oor_latency", lat, 4);
    xact(1'b0, 16'h0000, 32'h0, 1, rd, er, lat);
    check("t3_load0", rd, 32'hCAFEF00D);
    check("t3_load0_err", 32'(er), 0);
    xact(1'b0, 16'h8005, 32'h0, 1, rd, er, lat);
    check("t3_oor_load_err", 32'(er), 1);
    check("t3_oor_load_rdata", rd, 0);
    xact(1'b0, 16'h0005, 32'h0, 0, rd, er, lat);
    req_we = 1'b1; req_addr = 16'h0005; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2) == 0;
      @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid), 1);
      check("t4_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      check("t4_hold_ready", 32'(req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t4_release_valid", 32'(rsp_valid), 0);
    check("t4_release_ready", 32'(req_ready), 1);
    repeat (3) @(negedge clk);
    check("t4_no_second_accept", 32'(busy), 0);
    xact(1'b0, 16'h0005, 32'h0, 1, rd, er, lat);
    check("t4_mem_untouched", rd, 32'hDEADBEEF);
    xact(1'b1, 16'h0007, 32'h01020304, 1, rd, er, lat);
    xact(1'b0, 16'h0007, 32'h0, 1, rd, er, lat);
    check("raw_same_addr", rd, 32'h01020304);
    @(negedge clk);
    req_we = 1'b1; req_addr = 16'h0010; req_wdata = 32'h22222222; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_busy_in_wait", 32'(busy), 1);
    #2 rst_f = 1'b0;
    #1;
    check("t5_async_ready", 32'(req_ready), 1);
    check("t5_async_busy", 32'(busy), 0);
    check("t5_async_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst_f = 1'b1;
    xact(1'b0, 16'h0010, 32'h0, 1, rd, er, lat);
    check("t5_old_contents", rd, 32'h11111111);
    v_we[0] = 1'b1; v_d[0] = 32'hA5A5A5A5; v_exp[0] = 32'hA5A5A5A5;
    v_we[1] = 1'b0; v_d[1] = 32'h0;        v_exp[1] = 32'hA5A5A5A5;
    v_we[2] = 1'b1; v_d[2] = 32'h5A5A5A5A; v_exp[2] = 32'h5A5A5A5A;
    v_we[3] = 1'b0; v_d[3] = 32'h0;        v_exp[3] = 32'h5A5A5A5A;
    rsp_ready_b = 1'b1;
    repeat (40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid_b && j < 4) begin
        check("t6_rdata", rsp_rdata_b, v_exp[j]);
        check("t6_err", 32'(rsp_err_b), 0);
        if (last >= 0) check("t6_turnaround", cyc - last, 3);
        last = cyc;
        j++;
      end
      if (req_ready_b) begin
        if (k < 4) begin
          req_we_b = v_we[k]; req_addr_b = 16'h0020; req_wdata_b = v_d[k]; req_valid_b = 1'b1;
          k++;
        end else req_valid_b = 1'b0;
      end
    end
    check("t6_all_responses", j, 4);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
